pipe_seg_reg: RTL and testbench

Parametrised pipeline segment register for inter-stage boundaries (ID/EX first, then EX/MEM and MEM/WB). Carries LANES parallel instruction slots, each with a valid bit, PC, branch-prediction bit and a generic payload. Supports bubble (hold), flush (clear) and per-lane kill with in-order younger-lane squash. Optional saturating event counters for performance analysis.

---
 rtl/pipe_seg_pkg.sv | 28 ++
 rtl/pipe_seg_lane.sv | 40 ++++
 rtl/pipe_seg_reg.sv | 109 ++++++++++
 tb/tb_pipe_seg_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_seg_pkg.sv
// Shared types and helpers for the pipeline segment register.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: lane_meta_t (valid, pc, pred_taken), RESET_PC, STAT_W_DEF and sat_add().
// A full lane record is lane_meta_t plus a PAYLOAD_W payload. The payload is
// carried beside the struct because its width is a per-instance parameter.
package pipe_seg_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam int          STAT_W_DEF = 16;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
  } lane_meta_t;

  // The sum is formed at 33 bits so an overflow past max is seen and clamped
  // instead of wrapping around.
  function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                          input logic [31:0] inc,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/pipe_seg_lane.sv
// Single-lane segment register: clear zeroes the lane, hold keeps it, otherwise it loads.
// Latency: 1 cycle from input to output.
// Backpressure: i_hold freezes the lane. i_clear takes priority over i_hold.
// Ports: clk, rst_n (async active-low), i_hold, i_clear, i_meta/i_payload (lane in),
//        o_meta/o_payload (registered lane out).
module pipe_seg_lane
  import pipe_seg_pkg::*;
#(
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_hold,
  input  logic                 i_clear,
  input  lane_meta_t           i_meta,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output lane_meta_t           o_meta,
  output logic [PAYLOAD_W-1:0] o_payload
);

  lane_meta_t           r_meta;
  logic [PAYLOAD_W-1:0] r_payload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta    <= '{valid: 1'b0, pc: RESET_PC, pred_taken: 1'b0};
      r_payload <= '0;
    end else if (i_clear) begin
      r_meta    <= '{valid: 1'b0, pc: RESET_PC, pred_taken: 1'b0};
      r_payload <= '0;
    end else if (!i_hold) begin
      r_meta    <= i_meta;
      r_payload <= i_payload;
    end
  end

  assign o_meta    = r_meta;
  assign o_payload = r_payload;

endmodule

// File: rtl/pipe_seg_reg.sv
// Multi-lane pipeline segment register with flush, bubble and per-lane kill (younger-lane squash).
// Latency: 1 cycle from input to output.
// Backpressure: bubble holds every lane. flush overrides bubble. kill_lane is ignored unless loading.
// Ports: clk, rst_n, bubble, flush, kill_lane, valid_in/pc_in/pred_taken_in/payload_in (lane k
//        at slice k), the matching *_out registers, and stat_bubble/stat_flush/stat_retired.
// Optional: define PIPE_SEG_STATS_EN to build the saturating event counters. Without it the
//        stat outputs are tied to 0.
module pipe_seg_reg
  import pipe_seg_pkg::*;
#(
  parameter int PAYLOAD_W = 64,
  parameter int LANES     = 1,
  parameter int STAT_W    = STAT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bubble,
  input  logic                       flush,
  input  logic [LANES-1:0]           kill_lane,
  input  logic [LANES-1:0]           valid_in,
  input  logic [32*LANES-1:0]        pc_in,
  input  logic [LANES-1:0]           pred_taken_in,
  input  logic [PAYLOAD_W*LANES-1:0] payload_in,
  output logic [LANES-1:0]           valid_out,
  output logic [32*LANES-1:0]        pc_out,
  output logic [LANES-1:0]           pred_taken_out,
  output logic [PAYLOAD_W*LANES-1:0] payload_out,
  output logic [STAT_W-1:0]          stat_bubble,
  output logic [STAT_W-1:0]          stat_flush,
  output logic [STAT_W-1:0]          stat_retired
);

  logic [LANES-1:0] w_ek;    // effective kill: a lane is squashed if it or any older lane is killed
  logic             w_load;

  assign w_load = !flush && !bubble;

  always_comb begin
    w_ek    = '0;
    w_ek[0] = kill_lane[0];
    for (int k = 1; k < LANES; k++) begin
      w_ek[k] = w_ek[k-1] | kill_lane[k];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_meta_t w_d_meta;
    lane_meta_t w_q_meta;

    assign w_d_meta = '{valid: valid_in[k], pc: pc_in[32*k +: 32], pred_taken: pred_taken_in[k]};

    // A killed lane loads as flushed. During a bubble the kill is ignored.
    pipe_seg_lane #(.PAYLOAD_W(PAYLOAD_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hold   (bubble),
      .i_clear  (flush || (!bubble && w_ek[k])),
      .i_meta   (w_d_meta),
      .i_payload(payload_in[PAYLOAD_W*k +: PAYLOAD_W]),
      .o_meta   (w_q_meta),
      .o_payload(payload_out[PAYLOAD_W*k +: PAYLOAD_W])
    );

    assign valid_out[k]         = w_q_meta.valid;
    assign pc_out[32*k +: 32]   = w_q_meta.pc;
    assign pred_taken_out[k]    = w_q_meta.pred_taken;
  end

`ifdef PIPE_SEG_STATS_EN
  localparam logic [31:0] STAT_MAX = (32'd1 << STAT_W) - 32'd1;

  logic [STAT_W-1:0] r_stat_bubble;
  logic [STAT_W-1:0] r_stat_flush;
  logic [STAT_W-1:0] r_stat_retired;
  logic [31:0]       w_ret_cnt;

  always_comb begin
    w_ret_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      w_ret_cnt = w_ret_cnt + {31'd0, valid_in[k] & ~w_ek[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_bubble  <= '0;
      r_stat_flush   <= '0;
      r_stat_retired <= '0;
    end else if (flush) begin
      r_stat_flush <= STAT_W'(sat_add(32'(r_stat_flush), 32'd1, STAT_MAX));
    end else if (bubble) begin
      r_stat_bubble <= STAT_W'(sat_add(32'(r_stat_bubble), 32'd1, STAT_MAX));
    end else if (w_load) begin
      r_stat_retired <= STAT_W'(sat_add(32'(r_stat_retired), w_ret_cnt, STAT_MAX));
    end
  end

  assign stat_bubble  = r_stat_bubble;
  assign stat_flush   = r_stat_flush;
  assign stat_retired = r_stat_retired;
`else
  logic w_unused_load;
  assign w_unused_load = w_load;
  assign stat_bubble   = '0;
  assign stat_flush    = '0;
  assign stat_retired  = '0;
`endif

endmodule

// File: tb/tb_pipe_seg_reg.sv
module tb_pipe_seg_reg;

  localparam int PW     = 64;
  localparam int LN     = 2;
  localparam int SW     = 4;
  localparam int SATMAX = 15;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           bubble, flush;
  logic [LN-1:0]  kill_lane, valid_in, pred_taken_in;
  logic [32*LN-1:0] pc_in;
  logic [PW*LN-1:0] payload_in;
  logic [LN-1:0]  valid_out, pred_taken_out;
  logic [32*LN-1:0] pc_out;
  logic [PW*LN-1:0] payload_out;
  logic [SW-1:0]  stat_bubble, stat_flush, stat_retired;

  pipe_seg_reg #(.PAYLOAD_W(PW), .LANES(LN), .STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .bubble(bubble), .flush(flush), .kill_lane(kill_lane),
    .valid_in(valid_in), .pc_in(pc_in), .pred_taken_in(pred_taken_in), .payload_in(payload_in),
    .valid_out(valid_out), .pc_out(pc_out), .pred_taken_out(pred_taken_out),
    .payload_out(payload_out), .stat_bubble(stat_bubble), .stat_flush(stat_flush),
    .stat_retired(stat_retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what each lane should hold, plus plain event tallies.
  logic        m_valid [LN];
  logic [31:0] m_pc    [LN];
  logic        m_pred  [LN];
  logic [63:0] m_pay   [LN];
  int          m_nbub, m_nflush, m_nret;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SATMAX) ? SATMAX : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < LN; k++) begin
      m_valid[k] = 0; m_pc[k] = 0; m_pred[k] = 0; m_pay[k] = 0;
    end
    m_nbub = 0; m_nflush = 0; m_nret = 0;
  endtask

  // One clock edge as seen from the specification's rules.
  task automatic model_edge();
    bit squashed;
    if (flush) begin
      for (int k = 0; k < LN; k++) begin
        m_valid[k] = 0; m_pc[k] = 0; m_pred[k] = 0; m_pay[k] = 0;
      end
      m_nflush = sat(m_nflush + 1);
    end else if (bubble) begin
      m_nbub = sat(m_nbub + 1);
    end else begin
      squashed = 0;
      for (int k = 0; k < LN; k++) begin
        if (kill_lane[k]) squashed = 1;
        if (squashed) begin
          m_valid[k] = 0; m_pc[k] = 0; m_pred[k] = 0; m_pay[k] = 0;
        end else begin
          m_valid[k] = valid_in[k];
          m_pc[k]    = pc_in[32*k +: 32];
          m_pred[k]  = pred_taken_in[k];
          m_pay[k]   = payload_in[PW*k +: PW];
          if (valid_in[k]) m_nret = sat(m_nret + 1);
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int eb, ef, er;
`ifdef PIPE_SEG_STATS_EN
    eb = m_nbub; ef = m_nflush; er = m_nret;
`else
    eb = 0; ef = 0; er = 0;
`endif
    for (int k = 0; k < LN; k++) begin
      chk($sformatf("%s.valid%0d", tag, k), 64'(valid_out[k]), 64'(m_valid[k]));
      chk($sformatf("%s.pc%0d", tag, k), 64'(pc_out[32*k +: 32]), 64'(m_pc[k]));
      chk($sformatf("%s.pred%0d", tag, k), 64'(pred_taken_out[k]), 64'(m_pred[k]));
      chk($sformatf("%s.pay%0d", tag, k), payload_out[PW*k +: PW], m_pay[k]);
    end
    chk({tag, ".stat_bubble"}, 64'(stat_bubble), 64'(eb));
    chk({tag, ".stat_flush"}, 64'(stat_flush), 64'(ef));
    chk({tag, ".stat_retired"}, 64'(stat_retired), 64'(er));
  endtask

  task automatic drive(input logic fl, input logic bu, input logic [1:0] kl, input logic [1:0] vl,
                       input logic [31:0] pc0, input logic [31:0] pc1, input logic [1:0] pr,
                       input logic [63:0] p0, input logic [63:0] p1);
    @(negedge clk);
    flush = fl; bubble = bu; kill_lane = kl; valid_in = vl;
    pc_in = {pc1, pc0}; pred_taken_in = pr; payload_in = {p1, p0};
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; bubble = 0; kill_lane = 0;
    valid_in = 2'b11; pc_in = {32'h104, 32'h100}; pred_taken_in = 2'b11;
    payload_in = {64'hAAAA, 64'h5555};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 0, 2'b00, 2'b01, 32'h100, 32'h0, 2'b00, 64'h11, 64'h22);
    cycle("first_load");

    drive(0, 0, 2'b00, 2'b01, 32'h200, 32'h204, 2'b11, 64'h33, 64'h44);
    cycle("load_200");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 2'b00, 2'b11, 32'h300, 32'h304, 2'b00, 64'h55, 64'h66);
      cycle("bubble_hold");
    end

    drive(1, 1, 2'b00, 2'b11, 32'h300, 32'h304, 2'b11, 64'h77, 64'h88);
    cycle("flush_over_bubble");

    drive(0, 0, 2'b01, 2'b11, 32'h400, 32'h404, 2'b11, 64'h99, 64'hAA);
    cycle("kill_lane0");
    drive(0, 0, 2'b10, 2'b11, 32'h400, 32'h404, 2'b11, 64'h99, 64'hAA);
    cycle("kill_lane1");
    drive(0, 1, 2'b11, 2'b11, 32'h500, 32'h504, 2'b00, 64'hBB, 64'hCC);
    cycle("kill_in_bubble");

    drive(0, 0, 2'b00, 2'b10, 32'h600, 32'h604, 2'b01, 64'hDD, 64'hEE);
    cycle("invalid_keeps_fields");

    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 2'b00, 2'b11, 32'h700, 32'h704, 2'b11, 64'h1, 64'h2);
      cycle("sat_bubble");
    end

    drive(0, 1, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 64'h0, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset_mid_bubble");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_reset("rand_reset");
      end else begin
        drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, 2'($urandom),
              $urandom, $urandom, 2'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom});
        cycle("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
